// File: rtl/wb4_to_pi1.sv
// Wishbone B4 pipelined slave that masters a PI1 bus: requests are queued in a small FIFO,
// issued one at a time on PI1, and acknowledged in order back to the Wishbone initiator.
//
// state   | meaning
// IDLE    | no PI1 transfer in flight; leaves as soon as a request is queued or being pushed
// REQ     | head request driven on PI1, waiting for rdy to accept it (head popped on accept)
// RESP    | PI1 op is NOOP, waiting for the completion cycle (rdy) to capture read data
module wb4_to_pi1 #(
  parameter int ARCHBITSZ = 32,
  parameter int FIFODEPTH = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      wb4_cyc_i,
  input  logic                                      wb4_stb_i,
  input  logic                                      wb4_we_i,
  input  logic [ARCHBITSZ-1:0]                      wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]                      wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0]                    wb4_sel_i,
  output logic                                      wb4_stall_o,
  output logic                                      wb4_ack_o,
  output logic [ARCHBITSZ-1:0]                      wb4_data_o,
  output logic [1:0]                                pi1_op_o,
  output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]  pi1_addr_o,
  output logic [ARCHBITSZ-1:0]                      pi1_data_o,
  input  logic [ARCHBITSZ-1:0]                      pi1_data_i,
  output logic [ARCHBITSZ/8-1:0]                    pi1_sel_o,
  input  logic                                      pi1_rdy_i
);

  localparam int LSB = $clog2(ARCHBITSZ/8);
  localparam int AW  = ARCHBITSZ - LSB;
  localparam int SW  = ARCHBITSZ/8;
  localparam int PW  = $clog2(FIFODEPTH);

  localparam logic [PW:0] PTR_ONE = 1;
  localparam logic [1:0]  OP_NOOP = 2'd0;
  localparam logic [1:0]  OP_WR   = 2'd1;
  localparam logic [1:0]  OP_RD   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  state_t state, state_next;

  logic                 fifo_we   [FIFODEPTH];
  logic [AW-1:0]        fifo_addr [FIFODEPTH];
  logic [ARCHBITSZ-1:0] fifo_data [FIFODEPTH];
  logic [SW-1:0]        fifo_sel  [FIFODEPTH];

  logic [PW:0]          wr_ptr, rd_ptr;
  logic [PW-1:0]        wr_idx, rd_idx;
  logic                 fifo_empty, fifo_full;
  logic                 push, pop, completion;
  logic                 abandon;
  logic                 cur_we;
  logic                 ack_q;
  logic [ARCHBITSZ-1:0] ack_data_q;
  logic [AW-1:0]        word_addr;

  logic                 head_we;
  logic [AW-1:0]        head_addr;
  logic [ARCHBITSZ-1:0] head_data;
  logic [SW-1:0]        head_sel;

  assign wr_idx     = wr_ptr[PW-1:0];
  assign rd_idx     = rd_ptr[PW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);

  // Stall uses only registered state, so a pop in the same cycle never frees a slot early.
  assign wb4_stall_o = fifo_full | rst_i | abandon;
  assign push        = wb4_cyc_i & wb4_stb_i & ~wb4_stall_o;
  assign pop         = (state == ST_REQ) & pi1_rdy_i;
  assign completion  = (state == ST_RESP) & pi1_rdy_i;
  assign word_addr   = AW'(wb4_addr_i >> LSB);

  assign head_we   = fifo_we[rd_idx];
  assign head_addr = fifo_addr[rd_idx];
  assign head_data = fifo_data[rd_idx];
  assign head_sel  = fifo_sel[rd_idx];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_we[wr_idx]   <= wb4_we_i;
      fifo_addr[wr_idx] <= word_addr;
      fifo_data[wr_idx] <= wb4_data_i;
      fifo_sel[wr_idx]  <= wb4_sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (!fifo_empty || push) state_next = ST_REQ;
      ST_REQ:  if (pi1_rdy_i)           state_next = ST_RESP;
      ST_RESP: if (pi1_rdy_i)           state_next = ST_IDLE;
      default:                          state_next = ST_IDLE;
    endcase
  end

  // Abandon lasts until every queued and in-flight PI1 op has drained; their acks are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      abandon <= 1'b0;
    end else if (abandon) begin
      abandon <= !(fifo_empty && state == ST_IDLE);
    end else begin
      abandon <= !wb4_cyc_i && (!fifo_empty || state != ST_IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_we     <= 1'b0;
      ack_q      <= 1'b0;
      ack_data_q <= '0;
    end else begin
      if (pop) cur_we <= head_we;
      ack_q      <= completion & wb4_cyc_i & ~abandon;
      ack_data_q <= (completion && wb4_cyc_i && !abandon && !cur_we) ? pi1_data_i : '0;
    end
  end

  assign wb4_ack_o  = ack_q & ~rst_i;
  assign wb4_data_o = rst_i ? '0 : ack_data_q;

  always_comb begin
    pi1_op_o   = OP_NOOP;
    pi1_addr_o = '0;
    pi1_data_o = '0;
    pi1_sel_o  = '0;
    if (state == ST_REQ && !rst_i) begin
      pi1_op_o   = head_we ? OP_WR : OP_RD;
      pi1_addr_o = head_addr;
      pi1_data_o = head_data;
      pi1_sel_o  = head_sel;
    end
  end

endmodule

// File: tb/tb_wb4_to_pi1.sv
// Directed bench for wb4_to_pi1: inputs change 1ns after the rising edge, outputs are
// sampled on the falling edge; a tiny PI1 slave model supplies address-derived read data.
module tb_wb4_to_pi1;

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, rdy = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  sel = '0;
  logic        stall, ack;
  logic [31:0] rdata;
  logic [1:0]  op;
  logic [29:0] paddr;
  logic [31:0] pdata_o, pdata_i;
  logic [3:0]  psel;

  int checks = 0;
  int failures = 0;

  logic        model_en = 1'b0;
  logic [31:0] rd_fixed = '0;
  logic [29:0] slave_addr = '0;
  assign pdata_i = model_en ? (32'hA500_0000 | {2'b00, slave_addr}) : rd_fixed;

  int          ack_cnt = 0;
  int          issue_cnt = 0;
  logic [31:0] ack_data_q[$];
  logic [29:0] issue_addr_q[$];

  wb4_to_pi1 #(.ARCHBITSZ(32), .FIFODEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb4_cyc_i(cyc), .wb4_stb_i(stb), .wb4_we_i(we),
    .wb4_addr_i(addr), .wb4_data_i(wdata), .wb4_sel_i(sel),
    .wb4_stall_o(stall), .wb4_ack_o(ack), .wb4_data_o(rdata),
    .pi1_op_o(op), .pi1_addr_o(paddr), .pi1_data_o(pdata_o),
    .pi1_data_i(pdata_i), .pi1_sel_o(psel), .pi1_rdy_i(rdy)
  );

  always @(posedge clk_i) if (op != 2'd0 && rdy) slave_addr <= paddr;

  always @(negedge clk_i) begin
    if (ack) begin
      ack_cnt++;
      ack_data_q.push_back(rdata);
    end
    if (op != 2'd0 && rdy) begin
      issue_cnt++;
      issue_addr_q.push_back(paddr);
    end
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid;
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    rst_i = 1'b1; cyc = 1'b0; stb = 1'b0; rdy = 1'b0;
    step; step; mid;
    checks++; if (op !== 2'd0) begin failures++; $display("FAIL reset_op got=%0h exp=0", op); end
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", ack); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%0b exp=1", stall); end
    checks++; if ({paddr, rdata} !== 62'd0) begin failures++; $display("FAIL reset_zero got=%0h/%0h exp=0/0", paddr, rdata); end
    step; rst_i = 1'b0; mid;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL post_reset_stall got=%0b exp=0", stall); end
  endtask

  task automatic test_single_read;
    int base;
    base = ack_cnt; model_en = 1'b0; rd_fixed = 32'hCAFE_F00D; rdy = 1'b1;
    step; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h1004; sel = 4'hF; wdata = '0; mid;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rd_accept stall got=%0b exp=0", stall); end
    step; stb = 1'b0; mid;
    checks++; if (op !== 2'd2) begin failures++; $display("FAIL rd_op got=%0h exp=2", op); end
    checks++; if (paddr !== 30'h401) begin failures++; $display("FAIL rd_addr got=%0h exp=401", paddr); end
    step; mid;
    checks++; if ({op, ack} !== 3'b000) begin failures++; $display("FAIL rd_resp op/ack got=%0h/%0b exp=0/0", op, ack); end
    step; mid;
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rd_ack got=%0b exp=1", ack); end
    checks++; if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL rd_data got=%0h exp=cafef00d", rdata); end
    step; cyc = 1'b0; mid;
    checks++; if (ack_cnt - base !== 1) begin failures++; $display("FAIL rd_ack_count got=%0d exp=1", ack_cnt - base); end
  endtask

  task automatic test_write;
    int base;
    base = ack_cnt; model_en = 1'b0; rd_fixed = 32'hCAFE_F00D; rdy = 1'b1;
    step; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'b0011; wdata = 32'h1234_5678; mid;
    step; stb = 1'b0; mid;
    checks++; if (op !== 2'd1) begin failures++; $display("FAIL wr_op got=%0h exp=1", op); end
    checks++; if (paddr !== 30'h8) begin failures++; $display("FAIL wr_addr got=%0h exp=8", paddr); end
    checks++; if ({pdata_o, psel} !== {32'h1234_5678, 4'b0011}) begin
      failures++; $display("FAIL wr_data_sel got=%0h/%0h exp=12345678/3", pdata_o, psel);
    end
    step; mid; step; mid;
    checks++; if ({ack, rdata} !== {1'b1, 32'h0}) begin failures++; $display("FAIL wr_ack got=%0b/%0h exp=1/0", ack, rdata); end
    step; cyc = 1'b0; mid;
    checks++; if (ack_cnt - base !== 1) begin failures++; $display("FAIL wr_ack_count got=%0d exp=1", ack_cnt - base); end
  endtask

  task automatic test_burst;
    int base_ack, base_iss, idx, acc_at_stall;
    base_ack = ack_cnt; base_iss = issue_cnt; idx = 0; acc_at_stall = -1;
    ack_data_q.delete(); issue_addr_q.delete();
    model_en = 1'b1; rdy = 1'b0;
    step; cyc = 1'b1;
    for (int c = 0; c < 200 && idx < 6; c++) begin
      if (acc_at_stall >= 0) rdy = 1'b1;
      stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h100 + 32'(4 * idx);
      mid;
      if (stall && acc_at_stall < 0) acc_at_stall = idx;
      if (!stall) idx++;
      step;
    end
    stb = 1'b0; rdy = 1'b1;
    for (int c = 0; c < 100 && (ack_cnt - base_ack) < 6; c++) step;
    cyc = 1'b0;
    checks++; if (acc_at_stall !== 4) begin failures++; $display("FAIL burst_stall_point got=%0d exp=4", acc_at_stall); end
    checks++; if (idx !== 6) begin failures++; $display("FAIL burst_accepted got=%0d exp=6", idx); end
    checks++; if (ack_cnt - base_ack !== 6) begin failures++; $display("FAIL burst_acks got=%0d exp=6", ack_cnt - base_ack); end
    checks++; if (issue_cnt - base_iss !== 6) begin failures++; $display("FAIL burst_issued got=%0d exp=6", issue_cnt - base_iss); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= issue_addr_q.size() || i >= ack_data_q.size()) begin
        failures++; $display("FAIL burst_order[%0d] got=missing exp=present", i);
      end else if ({issue_addr_q[i], ack_data_q[i]} !== {30'h40 + 30'(i), 32'hA500_0040 + 32'(i)}) begin
        failures++;
        $display("FAIL burst_order[%0d] got=%0h/%0h exp=%0h/%0h", i, issue_addr_q[i], ack_data_q[i],
                 30'h40 + 30'(i), 32'hA500_0040 + 32'(i));
      end
    end
    model_en = 1'b0;
  endtask

  task automatic test_rdy_wait;
    int base;
    base = ack_cnt; model_en = 1'b0; rdy = 1'b0;
    step; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h3C; sel = 4'hF; wdata = 32'hA5A5_5A5A; mid;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL wait_accept stall got=%0b exp=0", stall); end
    step; stb = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mid;
      checks++; if ({op, paddr} !== {2'd1, 30'hF}) begin
        failures++; $display("FAIL wait_hold[%0d] got=%0h/%0h exp=1/f", k, op, paddr);
      end
      step;
    end
    rdy = 1'b1; mid;
    step; step; mid;
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wait_ack got=%0b exp=1", ack); end
    step; cyc = 1'b0; mid;
    checks++; if (ack_cnt - base !== 1) begin failures++; $display("FAIL wait_ack_count got=%0d exp=1", ack_cnt - base); end
  endtask

  task automatic test_abandon;
    int base_ack, base_iss, acc;
    logic drained;
    base_ack = ack_cnt; base_iss = issue_cnt; acc = 0; drained = 1'b0;
    model_en = 1'b0; rdy = 1'b0;
    step; cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      addr = 32'h200 + 32'(4 * i); wdata = 32'(i);
      mid;
      if (!stall) acc++;
      step;
    end
    cyc = 1'b0; stb = 1'b0; mid;
    step; rdy = 1'b1; cyc = 1'b1; mid;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL abandon_stall got=%0b exp=1", stall); end
    for (int c = 0; c < 60 && !drained; c++) begin
      step; mid;
      if (!stall) drained = 1'b1;
    end
    checks++; if ({drained, acc[3:0]} !== {1'b1, 4'd3}) begin
      failures++; $display("FAIL abandon_drain got=%0b/%0d exp=1/3", drained, acc);
    end
    checks++; if (issue_cnt - base_iss !== 3) begin failures++; $display("FAIL abandon_issued got=%0d exp=3", issue_cnt - base_iss); end
    checks++; if (ack_cnt - base_ack !== 0) begin failures++; $display("FAIL abandon_acks got=%0d exp=0", ack_cnt - base_ack); end
    rd_fixed = 32'h5EED_1234;
    step; stb = 1'b1; we = 1'b0; addr = 32'h44; mid;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL abandon_new_accept stall got=%0b exp=0", stall); end
    step; stb = 1'b0;
    for (int c = 0; c < 10 && ack_cnt == base_ack; c++) step;
    step; cyc = 1'b0;
    checks++; if (ack_cnt - base_ack !== 1 || ack_data_q[$] !== 32'h5EED_1234) begin
      failures++; $display("FAIL abandon_after_read got=%0d/%0h exp=1/5eed1234", ack_cnt - base_ack, ack_data_q[$]);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    base = ack_cnt; model_en = 1'b0; rd_fixed = 32'h0BAD_BEEF; rdy = 1'b1;
    step; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h80; sel = 4'hF; mid;
    step; stb = 1'b0; mid;
    step; rst_i = 1'b1; mid;
    step; mid;
    checks++; if ({op, ack, stall} !== 4'b0001) begin
      failures++; $display("FAIL rst_mid got=op%0h ack%0b stall%0b exp=op0 ack0 stall1", op, ack, stall);
    end
    step; rst_i = 1'b0; mid;
    checks++; if ({ack, stall} !== 2'b00) begin failures++; $display("FAIL rst_release got=%0b%0b exp=00", ack, stall); end
    checks++; if (ack_cnt - base !== 0) begin failures++; $display("FAIL rst_stray_ack got=%0d exp=0", ack_cnt - base); end
    rd_fixed = 32'h600D_F00D;
    step; stb = 1'b1; addr = 32'h84; mid;
    step; stb = 1'b0;
    for (int c = 0; c < 10 && ack_cnt == base; c++) step;
    step; cyc = 1'b0;
    checks++; if (ack_cnt - base !== 1 || ack_data_q[$] !== 32'h600D_F00D) begin
      failures++; $display("FAIL rst_post_read got=%0d/%0h exp=1/600df00d", ack_cnt - base, ack_data_q[$]);
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write;
    test_burst;
    test_rdy_wait;
    test_abandon;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
